restoring_div: RTL
==================

RESTORING_DIV -- requirements
Module: restoring_div

Interface
REQ-001 SHALL have parameter W, default 16, divisor/quotient/remainder width; the dividend is 2*W bits wide.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  2*W  numerator, sampled on the accepting edge.
REQ-006 SHALL have port divisor  input  W  denominator, sampled on the accepting edge.
REQ-007 SHALL have port busy  output  1  high in CALC and DONE.
REQ-008 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have port quotient  output  W  result quotient.
REQ-010 SHALL have port remainder  output  W  result remainder.
REQ-011 SHALL have port div_by_zero  output  1  error flag, divisor was 0.
REQ-012 SHALL have port overflow  output  1  error flag, quotient does not fit in W bits.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE; the reset state is IDLE.
REQ-014 SHALL accept a request when start=1 in IDLE at edge T.
- Operands are registered at T.
- div_by_zero and overflow are cleared at T.
REQ-015 SHALL, at an accepting edge with divisor=0, enter DONE directly.
- quotient=all ones, remainder=dividend[W-1:0], div_by_zero=1.
REQ-016 SHALL, at an accepting edge with divisor!=0 and dividend[2W-1:W] >= divisor, enter DONE directly.
- quotient=all ones, remainder=dividend[W-1:0], overflow=1.
REQ-017 SHALL, at any other accepting edge, enter CALC with the iteration counter at 0.
REQ-018 SHALL perform one restoring step per CALC cycle, W steps in total.
- Shift the partial remainder left by one (W+1-bit working width) and bring in the next dividend bit, MSB first.
- Subtract the divisor if it is not larger, and set the quotient bit.
REQ-019 SHALL write quotient and remainder and enter DONE on edge T+W.
REQ-020 SHALL assert done during exactly one cycle:
- Normal case: the cycle after edge T+W.
- Error case: the cycle after edge T.
- Return to IDLE on the following edge.
REQ-021 SHALL ignore start while in CALC or DONE; no queuing.
REQ-022 SHALL accept a new start on the first IDLE edge, giving a back-to-back throughput of one operation per W+2 cycles.
REQ-023 SHALL hold quotient, remainder and both flags stable from done until the next completion; the flags are cleared only at acceptance.
REQ-024 SHALL keep intermediate values off the quotient and remainder outputs during CALC; both hold their previous results.
REQ-025 SHALL produce results satisfying dividend = quotient*divisor + remainder with remainder < divisor whenever no flag is set.

Reset
REQ-026 SHALL, on any edge with rst_n=0 (including mid-CALC), force:
- state=IDLE, counter=0;
- busy=0, done=0;
- quotient=0, remainder=0, div_by_zero=0, overflow=0.
REQ-027 SHALL ignore start on an edge with rst_n=0, and accept start on the first edge with rst_n=1.

Verification
REQ-028 SHALL be verified by these directed scenarios (W=16):
- dividend=6438 (111*58), divisor=58, start at T -> done high in the cycle after T+16; quotient=111, remainder=0, both flags 0.
- dividend=6441, divisor=58 -> quotient=111, remainder=3; start pulsed during CALC is ignored and busy stays 1.
- dividend=0x0001_2345, divisor=0 -> done in the cycle after T; div_by_zero=1, quotient=0xFFFF, remainder=0x2345.
- dividend=0x0001_0000, divisor=1 -> done in the cycle after T; overflow=1, quotient=0xFFFF, remainder=0x0000.
- dividend=0xFFFE_0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0; a back-to-back start on the first IDLE cycle is accepted.
- rst_n=0 for one edge at T+8 of a running divide -> next cycle busy=0, done=0, all outputs 0; a subsequent 100/7 completes with quotient=14, remainder=2.

Source files
------------

// File: rtl/restoring_div.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per cycle. Divide-by-zero and quotient overflow are resolved at acceptance.
module restoring_div #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvs;
  logic [W-1:0]  prem;   // partial remainder, always < dvs between steps
  logic [W-1:0]  lo;     // unconsumed dividend bits shift out, quotient bits shift in

  logic [W:0]    sh;
  logic [W:0]    diff;
  logic          fits;
  logic [W-1:0]  prem_nxt;
  logic [W-1:0]  lo_nxt;

  always_comb begin
    sh       = {prem, lo[W-1]};
    diff     = sh - {1'b0, dvs};
    fits     = (sh >= {1'b0, dvs});
    prem_nxt = fits ? diff[W-1:0] : sh[W-1:0];
    lo_nxt   = {lo[W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvs         <= '0;
      prem        <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dvs         <= divisor;
            prem        <= dividend[2*W-1:W];
            lo          <= dividend[W-1:0];
            cnt         <= '0;
            busy        <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[W-1:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else if (dividend[2*W-1:W] >= divisor) begin
              // high half already >= divisor: quotient cannot fit in W bits
              quotient  <= '1;
              remainder <= dividend[W-1:0];
              overflow  <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= prem_nxt;
          lo   <= lo_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            quotient  <= lo_nxt;
            remainder <= prem_nxt;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
